// File: rtl/controller_pkg.sv
// Shared constants and control bundles for the pipelined MIPS controller:
// opcode/funct values, ALU/operand/destination encodings, and a helper
// that builds the common "writes a register" control word.
package controller_pkg;

   // Opcode field values
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // Funct field values (R-type only)
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_XNOR  = 6'b101000;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_MFHI  = 6'b001010;
   localparam logic [5:0] FN_MFLO  = 6'b001011;

   // ALU operation codes
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_XOR   = 4'b0011;
   localparam logic [3:0] ALU_XNOR  = 4'b0100;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_PASSB = 4'b1000;

   // ALU B-operand source
   localparam logic [1:0] SRC_REG  = 2'b00;
   localparam logic [1:0] SRC_SIMM = 2'b01;
   localparam logic [1:0] SRC_ZIMM = 2'b10;
   localparam logic [1:0] SRC_LUI  = 2'b11;

   // Destination register select
   localparam logic [1:0] DST_RT = 2'b00;
   localparam logic [1:0] DST_RD = 2'b01;
   localparam logic [1:0] DST_RA = 2'b10;

   // Controls carried from Decode into Execute
   typedef struct packed {
      logic       regwrite;
      logic       memtoreg;
      logic       jal;
      logic       memwrite;
      logic       aluormult;
      logic       lohi;
      logic       multstart;
      logic       multsign;
      logic [3:0] alucontrol;
      logic [1:0] alusrc;
      logic [1:0] regdst;
   } ex_ctrl_t;

   // Full decoder output: pipelined part plus Decode-only branch/jump flags
   typedef struct packed {
      ex_ctrl_t ex;
      logic     beq;
      logic     bne;
      logic     jump;
   } dec_t;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
      logic jal;
      logic memwrite;
      logic aluormult;
      logic lohi;
   } mem_ctrl_t;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
      logic jal;
   } wb_ctrl_t;

   // Control word for an ALU instruction that writes a register
   function automatic ex_ctrl_t wr_ctrl(input logic [3:0] alu,
                                        input logic [1:0] src,
                                        input logic [1:0] dst);
      ex_ctrl_t c;
      c            = '0;
      c.regwrite   = 1'b1;
      c.alucontrol = alu;
      c.alusrc     = src;
      c.regdst     = dst;
      return c;
   endfunction

endpackage

// File: rtl/controller_if.sv
// Decode bundle: instruction fields in, decoded control word out.
// master = side that supplies op/fn and consumes the decode,
// slave  = the combinational decoder.
interface controller_if;
   import controller_pkg::*;

   logic [5:0] op;
   logic [5:0] fn;
   dec_t       dec;

   modport master (output op, output fn, input  dec);
   modport slave  (input  op, input  fn, output dec);
endinterface

// File: rtl/controller_decode.sv
// ctrl_decode: purely combinational opcode/funct decoder.
// Multiplier instructions decode only when CTRL_MULT_EN is defined;
// otherwise mult/multu/mfhi/mflo fall through as NOPs.
module ctrl_decode
   import controller_pkg::*;
(
   controller_if.slave dif
);

   dec_t d;

   // Decode op/fn into a control word; anything unlisted stays all-zero (NOP)
   always_comb begin
      d = '0;
      case (dif.op)
         OP_RTYPE: begin
            case (dif.fn)
               FN_ADD:  d.ex = wr_ctrl(ALU_ADD,  SRC_REG, DST_RD);
               FN_SUB:  d.ex = wr_ctrl(ALU_SUB,  SRC_REG, DST_RD);
               FN_AND:  d.ex = wr_ctrl(ALU_AND,  SRC_REG, DST_RD);
               FN_OR:   d.ex = wr_ctrl(ALU_OR,   SRC_REG, DST_RD);
               FN_SLT:  d.ex = wr_ctrl(ALU_SLT,  SRC_REG, DST_RD);
               FN_XNOR: d.ex = wr_ctrl(ALU_XNOR, SRC_REG, DST_RD);
`ifdef CTRL_MULT_EN
               FN_MULT: begin
                  d.ex.multstart = 1'b1;
                  d.ex.multsign  = 1'b1;
               end
               FN_MULTU: d.ex.multstart = 1'b1;
               FN_MFHI: begin
                  d.ex           = wr_ctrl(ALU_AND, SRC_REG, DST_RD);
                  d.ex.aluormult = 1'b1;
                  d.ex.lohi      = 1'b1;
               end
               FN_MFLO: begin
                  d.ex           = wr_ctrl(ALU_AND, SRC_REG, DST_RD);
                  d.ex.aluormult = 1'b1;
               end
`else
               FN_MULT, FN_MULTU, FN_MFHI, FN_MFLO: d = '0;
`endif
               default: d = '0;
            endcase
         end
         OP_LW: begin
            d.ex          = wr_ctrl(ALU_ADD, SRC_SIMM, DST_RT);
            d.ex.memtoreg = 1'b1;
         end
         OP_SW: begin
            d.ex          = wr_ctrl(ALU_ADD, SRC_SIMM, DST_RT);
            d.ex.regwrite = 1'b0;
            d.ex.memwrite = 1'b1;
         end
         OP_BEQ: begin
            d.ex.alucontrol = ALU_SUB;
            d.beq           = 1'b1;
         end
         OP_BNE: begin
            d.ex.alucontrol = ALU_SUB;
            d.bne           = 1'b1;
         end
         OP_ADDI: d.ex = wr_ctrl(ALU_ADD,   SRC_SIMM, DST_RT);
         OP_SLTI: d.ex = wr_ctrl(ALU_SLT,   SRC_SIMM, DST_RT);
         OP_ANDI: d.ex = wr_ctrl(ALU_AND,   SRC_ZIMM, DST_RT);
         OP_ORI:  d.ex = wr_ctrl(ALU_OR,    SRC_ZIMM, DST_RT);
         OP_XORI: d.ex = wr_ctrl(ALU_XOR,   SRC_ZIMM, DST_RT);
         OP_LUI:  d.ex = wr_ctrl(ALU_PASSB, SRC_LUI,  DST_RT);
         OP_J:    d.jump = 1'b1;
         OP_JAL: begin
            d.ex     = wr_ctrl(ALU_ADD, SRC_REG, DST_RA);
            d.ex.jal = 1'b1;
            d.jump   = 1'b1;
         end
         default: d = '0;
      endcase
      dif.dec = d;
   end

endmodule

// File: rtl/controller.sv
// controller: Decode-stage control plus the D->E, E->M and M->W control
// pipeline registers. Optional multiplier support via CTRL_MULT_EN; with it
// undefined the multiplier controls are held at 0.
module controller
   import controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opD,
   input  logic [5:0] fnD,
   input  logic       equalD,
   input  logic       flushE,
   output logic       regwriteW,
   output logic       memtoregW,
   output logic       jalW,
   output logic       regwriteM,
   output logic       memtoregM,
   output logic       jalM,
   output logic       memwriteM,
   output logic       aluormultM,
   output logic       lohiM,
   output logic       regwriteE,
   output logic       memtoregE,
   output logic       jalE,
   output logic       multstartE,
   output logic       multsignE,
   output logic [3:0] alucontrolE,
   output logic [1:0] alusrcE,
   output logic [1:0] regdstE,
   output logic       branchD,
   output logic       jumpD,
   output logic       pcsrcD
);

   controller_if dif ();

   assign dif.op = opD;
   assign dif.fn = fnD;

   ctrl_decode u_decode (.dif(dif));

   ex_ctrl_t  e_d, e_q;
   mem_ctrl_t m_d, m_q;
   wb_ctrl_t  w_d, w_q;

   // Decode-stage branch/jump resolution, no register stage
   assign branchD = dif.dec.beq | dif.dec.bne;
   assign jumpD   = dif.dec.jump;
   assign pcsrcD  = (dif.dec.beq & equalD) | (dif.dec.bne & ~equalD);

   // Next-state for each pipeline stage; multiplier fields forced low when the feature is absent
   always_comb begin
      e_d = dif.dec.ex;
`ifndef CTRL_MULT_EN
      e_d.multstart = 1'b0;
      e_d.multsign  = 1'b0;
      e_d.aluormult = 1'b0;
      e_d.lohi      = 1'b0;
`endif
      m_d = '{regwrite:  e_q.regwrite,  memtoreg: e_q.memtoreg,
              jal:       e_q.jal,       memwrite: e_q.memwrite,
              aluormult: e_q.aluormult, lohi:     e_q.lohi};
      w_d = '{regwrite: m_q.regwrite, memtoreg: m_q.memtoreg, jal: m_q.jal};
   end

   // D->E register: a flush inserts a bubble without touching later stages
   always_ff @(posedge clk) begin
      if (rst || flushE) e_q <= '0;
      else               e_q <= e_d;
   end

   // E->M and M->W registers
   always_ff @(posedge clk) begin
      if (rst) begin
         m_q <= '0;
         w_q <= '0;
      end else begin
         m_q <= m_d;
         w_q <= w_d;
      end
   end

   assign regwriteE   = e_q.regwrite;
   assign memtoregE   = e_q.memtoreg;
   assign jalE        = e_q.jal;
   assign multstartE  = e_q.multstart;
   assign multsignE   = e_q.multsign;
   assign alucontrolE = e_q.alucontrol;
   assign alusrcE     = e_q.alusrc;
   assign regdstE     = e_q.regdst;

   assign regwriteM  = m_q.regwrite;
   assign memtoregM  = m_q.memtoreg;
   assign jalM       = m_q.jal;
   assign memwriteM  = m_q.memwrite;
   assign aluormultM = m_q.aluormult;
   assign lohiM      = m_q.lohi;

   assign regwriteW = w_q.regwrite;
   assign memtoregW = w_q.memtoreg;
   assign jalW      = w_q.jal;

endmodule

// File: tb/tb_controller.sv
// Bench for controller. Expected control vectors (16 bits):
// [15] regwrite [14] memtoreg [13] jal [12] memwrite [11] aluormult
// [10] lohi [9] multstart [8] multsign [7:4] alucontrol [3:2] alusrc [1:0] regdst
module tb_controller;

   logic       clk;
   logic       rst;
   logic [5:0] opD;
   logic [5:0] fnD;
   logic       equalD;
   logic       flushE;
   logic       regwriteW, memtoregW, jalW;
   logic       regwriteM, memtoregM, jalM, memwriteM, aluormultM, lohiM;
   logic       regwriteE, memtoregE, jalE, multstartE, multsignE;
   logic [3:0] alucontrolE;
   logic [1:0] alusrcE, regdstE;
   logic       branchD, jumpD, pcsrcD;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_e_q[$];
   logic [15:0] exp_m_q[$];
   logic [15:0] exp_w_q[$];

`ifdef CTRL_MULT_EN
   localparam logic [15:0] X_MULT  = 16'h0300;
   localparam logic [15:0] X_MULTU = 16'h0200;
   localparam logic [15:0] X_MFHI  = 16'h8C01;
   localparam logic [15:0] X_MFLO  = 16'h8801;
`else
   localparam logic [15:0] X_MULT  = 16'h0000;
   localparam logic [15:0] X_MULTU = 16'h0000;
   localparam logic [15:0] X_MFHI  = 16'h0000;
   localparam logic [15:0] X_MFLO  = 16'h0000;
`endif

   controller dut (
      .clk(clk), .rst(rst), .opD(opD), .fnD(fnD), .equalD(equalD), .flushE(flushE),
      .regwriteW(regwriteW), .memtoregW(memtoregW), .jalW(jalW),
      .regwriteM(regwriteM), .memtoregM(memtoregM), .jalM(jalM),
      .memwriteM(memwriteM), .aluormultM(aluormultM), .lohiM(lohiM),
      .regwriteE(regwriteE), .memtoregE(memtoregE), .jalE(jalE),
      .multstartE(multstartE), .multsignE(multsignE),
      .alucontrolE(alucontrolE), .alusrcE(alusrcE), .regdstE(regdstE),
      .branchD(branchD), .jumpD(jumpD), .pcsrcD(pcsrcD)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] obs_e();
      return {regwriteE, memtoregE, jalE, 3'b000, multstartE, multsignE,
              alucontrolE, alusrcE, regdstE};
   endfunction

   function automatic logic [15:0] obs_m();
      return {regwriteM, memtoregM, jalM, memwriteM, aluormultM, lohiM, 10'b0};
   endfunction

   function automatic logic [15:0] obs_w();
      return {regwriteW, memtoregW, jalW, 13'b0};
   endfunction

   // Pop the expected word for each stage, compare, and advance it one stage
   task automatic compare_stages(input string tag);
      logic [15:0] e, m, w;
      if (exp_w_q.size() == 0 || exp_m_q.size() == 0 || exp_e_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s scoreboard underflow", tag);
      end else begin
         w = exp_w_q.pop_front();
         check({tag, "/W"}, obs_w(), {w[15:13], 13'b0});
         m = exp_m_q.pop_front();
         check({tag, "/M"}, obs_m(), {m[15:10], 10'b0});
         exp_w_q.push_back(m);
         e = exp_e_q.pop_front();
         check({tag, "/E"}, obs_e(), {e[15:13], 3'b000, e[9:0]});
         exp_m_q.push_back(e);
      end
   endtask

   // Drive one instruction in Decode, check D outputs, then the pipeline after the edge
   task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic eq, input logic fl, input logic [15:0] ev,
                       input logic [2:0] exp_d);
      @(negedge clk);
      rst    = 1'b0;
      opD    = op;
      fnD    = fn;
      equalD = eq;
      flushE = fl;
      #1;
      check({tag, "/D"}, {13'b0, branchD, jumpD, pcsrcD}, {13'b0, exp_d});
      exp_e_q.push_back(fl ? 16'h0000 : ev);
      @(posedge clk);
      #1;
      compare_stages(tag);
   endtask

   // Reset with an lw in Decode; every registered output must read 0
   task automatic do_reset(input logic fl);
      @(negedge clk);
      rst    = 1'b1;
      flushE = fl;
      opD    = 6'b100011;
      fnD    = 6'b000000;
      @(posedge clk);
      #1;
      check("rst/E", obs_e(), 16'h0000);
      check("rst/M", obs_m(), 16'h0000);
      check("rst/W", obs_w(), 16'h0000);
      exp_e_q.delete();
      exp_m_q.delete();
      exp_w_q.delete();
      exp_m_q.push_back(16'h0000);
      exp_w_q.push_back(16'h0000);
   endtask

   initial begin
      rst = 1'b1; opD = '0; fnD = '0; equalD = 1'b0; flushE = 1'b0;
      do_reset(1'b0);

      //   tag       op         fn         eq    fl    expected  {br,j,pc}
      step("beq1",  6'b000100, 6'b000000, 1'b1, 1'b0, 16'h0060, 3'b101);
      step("beq0",  6'b000100, 6'b000000, 1'b0, 1'b0, 16'h0060, 3'b100);
      step("lui",   6'b001111, 6'b000000, 1'b0, 1'b0, 16'h808C, 3'b000);
      step("xori",  6'b001110, 6'b000000, 1'b0, 1'b0, 16'h8038, 3'b000);
      step("xnor",  6'b000000, 6'b101000, 1'b0, 1'b0, 16'h8041, 3'b000);
      step("mult",  6'b000000, 6'b011000, 1'b0, 1'b0, X_MULT,   3'b000);
      step("multu", 6'b000000, 6'b011001, 1'b0, 1'b0, X_MULTU,  3'b000);
      step("mfhi",  6'b000000, 6'b001010, 1'b0, 1'b0, X_MFHI,   3'b000);
      step("mflo",  6'b000000, 6'b001011, 1'b0, 1'b0, X_MFLO,   3'b000);
      step("bne0",  6'b000101, 6'b000000, 1'b0, 1'b0, 16'h0060, 3'b101);
      step("bne1",  6'b000101, 6'b000000, 1'b1, 1'b0, 16'h0060, 3'b100);
      step("jal",   6'b000011, 6'b000000, 1'b1, 1'b0, 16'hA022, 3'b010);
      step("j",     6'b000010, 6'b000000, 1'b0, 1'b0, 16'h0000, 3'b010);
      step("add",   6'b000000, 6'b100000, 1'b0, 1'b0, 16'h8021, 3'b000);
      step("sub",   6'b000000, 6'b100010, 1'b0, 1'b0, 16'h8061, 3'b000);
      step("and",   6'b000000, 6'b100100, 1'b0, 1'b0, 16'h8001, 3'b000);
      step("or",    6'b000000, 6'b100101, 1'b0, 1'b0, 16'h8011, 3'b000);
      step("slt",   6'b000000, 6'b101010, 1'b0, 1'b0, 16'h8071, 3'b000);
      step("lw",    6'b100011, 6'b000000, 1'b0, 1'b0, 16'hC024, 3'b000);
      step("sw",    6'b101011, 6'b000000, 1'b0, 1'b0, 16'h1024, 3'b000);
      step("addi",  6'b001000, 6'b000000, 1'b0, 1'b0, 16'h8024, 3'b000);
      step("slti",  6'b001010, 6'b000000, 1'b0, 1'b0, 16'h8074, 3'b000);
      step("andi",  6'b001100, 6'b000000, 1'b0, 1'b0, 16'h8008, 3'b000);
      step("ori",   6'b001101, 6'b000000, 1'b0, 1'b0, 16'h8018, 3'b000);
      step("nop0",  6'b000000, 6'b000000, 1'b1, 1'b0, 16'h0000, 3'b000);

      // Unlisted opcodes and unlisted R-type functs decode as NOP
      for (int i = 0; i < 4; i++) begin
         step("rnd_op", 6'($urandom_range(48, 62)), 6'($urandom_range(0, 63)),
              1'($urandom_range(0, 1)), 1'b0, 16'h0000, 3'b000);
         step("rnd_fn", 6'b000000, 6'($urandom_range(48, 63)),
              1'($urandom_range(0, 1)), 1'b0, 16'h0000, 3'b000);
      end

      // Flush: lw behind a jal becomes a bubble while jal keeps flowing to W
      step("jal2",  6'b000011, 6'b000000, 1'b0, 1'b0, 16'hA022, 3'b010);
      step("lwfl",  6'b100011, 6'b000000, 1'b0, 1'b1, 16'hC024, 3'b000);
      step("addf",  6'b000000, 6'b100000, 1'b0, 1'b0, 16'h8021, 3'b000);
      step("mfhi2", 6'b000000, 6'b001010, 1'b0, 1'b0, X_MFHI,   3'b000);

      // Reset together with flush mid-stream, then refill
      do_reset(1'b1);
      step("lw2",   6'b100011, 6'b000000, 1'b0, 1'b0, 16'hC024, 3'b000);
      for (int i = 0; i < 3; i++)
         step("drain", 6'b000000, 6'b000000, 1'b0, 1'b0, 16'h0000, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
